// File: rtl/rsa_pkg.sv
// Shared RSA key constants, operand widths and the decrypt state enum.
// Encrypt-side blocks import the same constants so the key pair stays consistent.
package rsa_pkg;

    localparam int MSG_W  = 8;
    localparam int RES_W  = 16;
    localparam int PROD_W = 32;

    localparam logic [MSG_W-1:0] RSA_E = 8'd7;
    localparam logic [MSG_W-1:0] RSA_D = 8'd103;
    localparam logic [RES_W-1:0] RSA_N = 16'd143;

    localparam logic [2:0] LAST_BIT = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/rsa_modmul.sv
// Combinational modular multiply: the full 32-bit product of two residues is
// reduced mod N, so no bits are lost before the reduction.
module rsa_modmul
    import rsa_pkg::*;
#(
    parameter logic [RES_W-1:0] N = RSA_N
) (
    input  logic [RES_W-1:0] a_i,
    input  logic [RES_W-1:0] b_i,
    output logic [RES_W-1:0] p_o
);

    logic [PROD_W-1:0] prod;

    always_comb begin
        prod = PROD_W'(a_i) * PROD_W'(b_i);
        p_o  = RES_W'(prod % PROD_W'(N));
    end

endmodule

// File: rtl/rsa_decrypt.sv
// RSA decryption, right-to-left square-and-multiply, one exponent bit per cycle.
// Optional feature macro: RSA_DEC_RANGE_CHECK_EN flags ciphertexts >= N via err.
module rsa_decrypt
    import rsa_pkg::*;
#(
    parameter logic [MSG_W-1:0] D = RSA_D,
    parameter logic [RES_W-1:0] N = RSA_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [MSG_W-1:0] cipher,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [MSG_W-1:0] message,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err
);

    state_e           state_q, state_d;
    logic [RES_W-1:0] base_q, base_d;
    logic [RES_W-1:0] acc_q, acc_d;
    logic [MSG_W-1:0] exp_q, exp_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [MSG_W-1:0] message_q, message_d;

    logic [RES_W-1:0] cipherExt;
    logic [RES_W-1:0] accProd;
    logic [RES_W-1:0] baseProd;
    logic [RES_W-1:0] accNext;

`ifdef RSA_DEC_RANGE_CHECK_EN
    logic rangeErr_q, rangeErr_d;
    logic err_q, err_d;
`endif

    assign cipherExt = {{(RES_W-MSG_W){1'b0}}, cipher};

    rsa_modmul #(.N(N)) u_accMul (
        .a_i (acc_q),
        .b_i (base_q),
        .p_o (accProd)
    );

    rsa_modmul #(.N(N)) u_baseMul (
        .a_i (base_q),
        .b_i (base_q),
        .p_o (baseProd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            acc_q      <= '0;
            exp_q      <= '0;
            cnt_q      <= '0;
            message_q  <= '0;
`ifdef RSA_DEC_RANGE_CHECK_EN
            rangeErr_q <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            acc_q      <= acc_d;
            exp_q      <= exp_d;
            cnt_q      <= cnt_d;
            message_q  <= message_d;
`ifdef RSA_DEC_RANGE_CHECK_EN
            rangeErr_q <= rangeErr_d;
            err_q      <= err_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        acc_d      = acc_q;
        exp_d      = exp_q;
        cnt_d      = cnt_q;
        message_d  = message_q;
        accNext    = exp_q[0] ? accProd : acc_q;
`ifdef RSA_DEC_RANGE_CHECK_EN
        rangeErr_d = rangeErr_q;
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d    = RUN;
                    base_d     = cipherExt % N;
                    acc_d      = RES_W'(1);
                    exp_d      = D;
                    cnt_d      = '0;
`ifdef RSA_DEC_RANGE_CHECK_EN
                    rangeErr_d = (cipherExt >= N);
`endif
                end
            end
            RUN: begin
                acc_d  = accNext;
                base_d = baseProd;
                exp_d  = exp_q >> 1;
                cnt_d  = cnt_q + 3'd1;
                // Fixed 8-cycle latency: every exponent bit is walked, even leading zeros.
                if (cnt_q == LAST_BIT) begin
                    state_d   = DONE;
                    message_d = MSG_W'(accNext);
`ifdef RSA_DEC_RANGE_CHECK_EN
                    if (rangeErr_q) begin
                        message_d = '0;
                        err_d     = 1'b1;
                    end
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
`ifdef RSA_DEC_RANGE_CHECK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign message   = message_q;

`ifdef RSA_DEC_RANGE_CHECK_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_decrypt.sv
// Self-checking bench for rsa_decrypt: directed vector table, handshake and
// reset corner sequences, a D = 0 instance and a full encrypt/decrypt sweep.
module tb_rsa_decrypt;
    import rsa_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] cipher;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] message;
    logic       out_valid;
    logic       out_ready;
    logic       err;

    logic [7:0] cipher0;
    logic       inValid0;
    logic       inReady0;
    logic [7:0] message0;
    logic       outValid0;
    logic       outReady0;
    logic       err0;

    int checks;
    int errors;

    typedef struct {
        logic [7:0] cipher;
        logic [7:0] expMsg;
        logic       expErr;
    } vec_t;

    vec_t vecs[7];

    rsa_decrypt dut (
        .clk       (clk),
        .rst       (rst),
        .cipher    (cipher),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .message   (message),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    rsa_decrypt #(.D(8'd0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .cipher    (cipher0),
        .in_valid  (inValid0),
        .in_ready  (inReady0),
        .message   (message0),
        .out_valid (outValid0),
        .out_ready (outReady0),
        .err       (err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int modPow(input int b, input int e, input int n);
        int r;
        int bb;
        r  = 1;
        bb = b % n;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = (r * bb) % n;
            bb = (bb * bb) % n;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] c, output logic [7:0] msg,
                                 output logic e, output int lat);
        int waitCnt;
        waitCnt = 0;
        while (!in_ready && waitCnt < 20) begin
            tick();
            waitCnt++;
        end
        cipher   = c;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        msg       = message;
        e         = err;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic runAndCheck(input logic [7:0] c, input logic [7:0] expMsg, input logic expErr);
        logic [7:0] msg;
        logic       e;
        int         lat;
        applyStimulus(c, msg, e, lat);
        checkOutput($sformatf("message c=%0d", c), int'(msg), int'(expMsg));
        checkOutput($sformatf("err c=%0d", c), int'(e), int'(expErr));
        checkOutput($sformatf("latency c=%0d", c), lat, 8);
        checkOutput($sformatf("out_valid drop c=%0d", c), int'(out_valid), 0);
        checkOutput($sformatf("in_ready after handshake c=%0d", c), int'(in_ready), 1);
    endtask

    initial begin
        int  cnt;
        int  enc;
        logic sawValid;

        checks    = 0;
        errors    = 0;
        cipher    = 8'd128;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        cipher0   = 8'd0;
        inValid0  = 1'b0;
        outReady0 = 1'b1;
        rst       = 1'b1;

        vecs[0] = '{8'd128, 8'd2,   1'b0};
        vecs[1] = '{8'd47,  8'd5,   1'b0};
        vecs[2] = '{8'd142, 8'd142, 1'b0};
        vecs[3] = '{8'd0,   8'd0,   1'b0};
        vecs[4] = '{8'd1,   8'd1,   1'b0};
        vecs[5] = '{8'd57,  8'd8,   1'b0};
`ifdef RSA_DEC_RANGE_CHECK_EN
        vecs[6] = '{8'd200, 8'd0,   1'b1};
`else
        vecs[6] = '{8'd200, 8'd8,   1'b0};
`endif

        // Reset with in_valid asserted: reset must win.
        tick();
        tick();
        checkOutput("reset in_ready", int'(in_ready), 1);
        checkOutput("reset out_valid", int'(out_valid), 0);
        checkOutput("reset message", int'(message), 0);
        checkOutput("reset err", int'(err), 0);
        in_valid = 1'b0;
        rst      = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            runAndCheck(vecs[i].cipher, vecs[i].expMsg, vecs[i].expErr);
        end

        // Output held while out_ready is low; in_valid pulses are ignored.
        cipher   = 8'd47;
        in_valid = 1'b1;
        tick();
        cipher = 8'd1;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        checkOutput("hold latency", cnt, 8);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("hold out_valid", int'(out_valid), 1);
            checkOutput("hold message", int'(message), 5);
            checkOutput("hold in_ready", int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("hold release out_valid", int'(out_valid), 0);
        checkOutput("hold release in_ready", int'(in_ready), 1);
        runAndCheck(8'd128, 8'd2, 1'b0);

        // D = 0 instance returns 1 for any ciphertext.
        for (int i = 0; i < 3; i++) begin
            cipher0  = (i == 0) ? 8'd77 : (i == 1) ? 8'd0 : 8'd142;
            inValid0 = 1'b1;
            tick();
            inValid0 = 1'b0;
            cnt = 0;
            while (!outValid0 && cnt < 20) begin
                tick();
                cnt++;
            end
            checkOutput($sformatf("d0 message c=%0d", cipher0), int'(message0), 1);
            checkOutput($sformatf("d0 latency c=%0d", cipher0), cnt, 8);
            checkOutput("d0 err", int'(err0), 0);
            tick();
        end

        // Reset on the 4th RUN cycle aborts without a result.
        cipher   = 8'd128;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort in_ready", int'(in_ready), 1);
        checkOutput("abort out_valid", int'(out_valid), 0);
        checkOutput("abort message", int'(message), 0);
        sawValid = 1'b0;
        repeat (12) begin
            tick();
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("abort no result", int'(sawValid), 0);
        runAndCheck(8'd128, 8'd2, 1'b0);

        // Encrypt every m with e = 7 in the model, decrypt in the DUT.
        for (int m = 0; m < 143; m++) begin
            enc = modPow(m, int'(RSA_E), int'(RSA_N));
            runAndCheck(8'(enc), 8'(m), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rsa_decrypt.md
RSA_DECRYPT -- requirements
Module: rsa_decrypt

Interface
REQ-001 The block SHALL have parameter D, default 103: private exponent, 8 bits.
REQ-002 The block SHALL have parameter N, default 143: modulus (11*13), 16 bits, N > 1.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state SHALL update on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port cipher, input, 8 bits: ciphertext.
REQ-006 The block SHALL have port in_valid, input, 1 bit: cipher is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block can accept a ciphertext.
REQ-008 The block SHALL have port message, output, 8 bits: decrypted plaintext.
REQ-009 The block SHALL have port out_valid, output, 1 bit: message is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: consumer accepts message.
REQ-011 The block SHALL have port err, output, 1 bit: range error on the current result.

Function
REQ-012 The block SHALL compute message = cipher^D mod N by right-to-left square-and-multiply, one exponent bit per cycle.
REQ-013 The state machine SHALL have the states IDLE, RUN and DONE.
REQ-014 The transition IDLE->RUN SHALL occur on in_valid && in_ready; at that edge the block SHALL load base = cipher mod N, acc = 1, exp = D and bit counter = 0.
REQ-015 Each RUN cycle SHALL apply: if exp[0], acc <= acc*base mod N; base <= base*base mod N; exp <= exp >> 1; counter +1.
REQ-016 RUN SHALL last exactly 8 cycles regardless of D (fixed latency), and the transition RUN->DONE SHALL occur on the 8th RUN edge.
REQ-017 out_valid SHALL be asserted exactly 8 clock edges after the accepting edge.
REQ-018 DONE SHALL hold message, err and out_valid stable until out_ready is high.
REQ-019 The transition DONE->IDLE SHALL occur on out_valid && out_ready; out_valid SHALL drop at that edge.
REQ-020 in_ready SHALL be high only in IDLE; in_valid SHALL be ignored in RUN and DONE.
REQ-021 After an output handshake, in_ready SHALL be high on the following cycle; throughput SHALL be at most one result per 10 cycles.
REQ-022 Products SHALL be formed at 32 bits (two 16-bit residues), then reduced mod N; no truncation before reduction.
REQ-023 message SHALL be the low 8 bits of acc; for N <= 256 this is exact.
REQ-024 Boundaries: cipher = 0 SHALL give 0; cipher = 1 SHALL give 1; D = 0 SHALL give 1 for any cipher.

Reset
REQ-025 rst SHALL force IDLE, in_ready = 1, out_valid = 0, message = 0 and err = 0 on the next edge.
REQ-026 rst asserted during RUN or DONE SHALL abort the computation with no result delivered.
REQ-027 rst SHALL override in_valid and out_ready in the same cycle.

Configuration
REQ-028 Macro RSA_DEC_RANGE_CHECK_EN defined: a cipher >= N SHALL still run the full 8 cycles, then deliver message = 0 and err = 1 in DONE.
REQ-029 Macro RSA_DEC_RANGE_CHECK_EN undefined: a cipher >= N SHALL be reduced mod N at load, and err SHALL be tied to 0.

Structure
REQ-030 Package rsa_pkg SHALL hold the default constants (E = 7, D = 103, N = 143), the operand widths (8, 16, 32) and the state enum.
REQ-031 Sub-module rsa_modmul SHALL implement a combinational (a*b) mod N, with two instances, one for acc and one for base.
REQ-032 Encrypt-side blocks SHALL share rsa_pkg constants so the key pair stays consistent.

Verification
REQ-033 cipher = 128, in_valid 1 cycle -> message = 2, out_valid exactly 8 edges after acceptance, err = 0.
REQ-034 cipher = 47 -> message = 5; cipher = 142 -> message = 142; cipher = 0 -> 0; cipher = 1 -> 1.
REQ-035 out_ready held low for 5 cycles in DONE -> message/out_valid stable; in_valid pulses during RUN/DONE ignored; next ciphertext accepted the cycle after handshake.
REQ-036 rst asserted on the 4th RUN cycle -> IDLE next edge, out_valid never asserted, next ciphertext 128 decrypts to 2.
REQ-037 cipher = 200: macro defined -> message = 0, err = 1; macro undefined -> result equals that of cipher = 57, err = 0.
REQ-038 Random sweep of m in 0..142: encrypt with e = 7 in the model, decrypt in the DUT -> message = m for all m.
